// File: rtl/tug_score_keeper.sv
// Tug-of-war match scorekeeper: round win decode, per-player 0-7 scores, result hold with restart pulse.
// Optional SCORE_WINNER_LETTER_EN: the winner's digit shows a letter once the match is over.
module tug_score_keeper #(
    parameter int HOLD_CYCLES = 4,
    parameter int WIN_SCORE   = 7
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       L,
    input  logic       R,
    input  logic       NL,
    input  logic       NR,
    output logic       roundReset,
    output logic       freeze,
    output logic       matchOver,
    output logic [2:0] leftScore,
    output logic [2:0] rightScore,
    output logic [6:0] hexL,
    output logic [6:0] hexR
);
    localparam int             CW   = $clog2(HOLD_CYCLES);
    localparam logic [CW-1:0]  LAST = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0]  PRE  = CW'(HOLD_CYCLES - 2);
    localparam logic [2:0]     WIN  = 3'(WIN_SCORE);

    typedef enum logic [1:0] {PLAY, HOLD, OVER} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          leftWin, rightWin;

    assign leftWin  = L & ~R & NL;
    assign rightWin = R & ~L & NR;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= PLAY;
            cnt        <= '0;
            roundReset <= 1'b0;
            freeze     <= 1'b0;
            matchOver  <= 1'b0;
            leftScore  <= 3'd0;
            rightScore <= 3'd0;
        end else begin
            case (state)
                PLAY: begin
                    if (leftWin || rightWin) begin
                        freeze <= 1'b1;
                        cnt    <= '0;
                        if (leftWin) leftScore  <= leftScore + 3'd1;
                        else         rightScore <= rightScore + 3'd1;
                        if ((leftWin  && leftScore  + 3'd1 == WIN) ||
                            (rightWin && rightScore + 3'd1 == WIN)) begin
                            state     <= OVER;
                            matchOver <= 1'b1;
                        end else begin
                            state <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (cnt == LAST) begin
                        state      <= PLAY;
                        freeze     <= 1'b0;
                        roundReset <= 1'b0;
                        cnt        <= '0;
                    end else begin
                        cnt        <= cnt + 1'b1;
                        // Pulse lands on the final hold cycle so the playfield resets with the return to PLAY.
                        roundReset <= (cnt == PRE);
                    end
                end
                OVER: ;
                default: state <= PLAY;
            endcase
        end
    end

    function automatic logic [6:0] seg(input logic [2:0] v);
        case (v)
            3'd0: seg = 7'b1000000;
            3'd1: seg = 7'b1111001;
            3'd2: seg = 7'b0100100;
            3'd3: seg = 7'b0110000;
            3'd4: seg = 7'b0011001;
            3'd5: seg = 7'b0010010;
            3'd6: seg = 7'b0000010;
            default: seg = 7'b1111000;
        endcase
    endfunction

    always_comb begin
        hexL = seg(leftScore);
        hexR = seg(rightScore);
`ifdef SCORE_WINNER_LETTER_EN
        if (state == OVER) begin
            if (leftScore == WIN) hexL = 7'b1000111;
            else                  hexR = 7'b0101111;
        end
`endif
    end
endmodule

// File: tb/tb_tug_score_keeper.sv
// Directed bench for tug_score_keeper (HOLD_CYCLES=4, WIN_SCORE=7).
module tb_tug_score_keeper;
    logic       clk = 1'b0;
    logic       reset, L, R, NL, NR;
    logic       roundReset, freeze, matchOver;
    logic [2:0] leftScore, rightScore;
    logic [6:0] hexL, hexR;
    int         total = 0;
    int         bad   = 0;
    int         pulses;

    tug_score_keeper #(.HOLD_CYCLES(4), .WIN_SCORE(7)) dut (
        .clk(clk), .reset(reset), .L(L), .R(R), .NL(NL), .NR(NR),
        .roundReset(roundReset), .freeze(freeze), .matchOver(matchOver),
        .leftScore(leftScore), .rightScore(rightScore), .hexL(hexL), .hexR(hexR)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one active edge, then settle before sampling.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; L = 0; R = 0; NL = 0; NR = 0;
        #1;
        chk("rst_left", 32'(leftScore), 0);
        chk("rst_hexL", 32'(hexL), 32'b1000000);
        step(); step();
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("idle_scores", {leftScore, rightScore}, 0);
            chk("idle_hex", {hexL, hexR}, {7'b1000000, 7'b1000000});
            chk("idle_ctl", {freeze, roundReset, matchOver}, 0);
        end

        // Left win at edge k, then watch the 4-cycle hold.
        NL = 1; L = 1;
        step();
        L = 0;
        chk("k_left", 32'(leftScore), 1);
        chk("k_hexL", 32'(hexL), 32'b1111001);
        chk("k_ctl", {freeze, roundReset}, 2'b10);
        step(); chk("k1_ctl", {freeze, roundReset}, 2'b10);
        step(); chk("k2_ctl", {freeze, roundReset}, 2'b10);
        step(); chk("k3_ctl", {freeze, roundReset}, 2'b11);
        step(); chk("k4_ctl", {freeze, roundReset}, 2'b00);
        chk("k4_left", 32'(leftScore), 1);
        NL = 0;

        // Simultaneous presses never score.
        NR = 1; L = 1; R = 1;
        step();
        L = 0; R = 0;
        chk("both_scores", {leftScore, rightScore}, {3'd1, 3'd0});
        chk("both_freeze", 32'(freeze), 0);

        // Right win, presses held through the hold must not rescore.
        R = 1;
        step();
        chk("rw_right", 32'(rightScore), 1);
        chk("rw_hexR", 32'(hexR), 32'b1111001);
        pulses = 0;
        for (int i = 1; i <= 4; i++) begin
            R = (i < 4);
            step();
            if (roundReset) pulses++;
            chk("rw_hold_right", 32'(rightScore), 1);
        end
        chk("rw_pulses", 32'(pulses), 1);
        chk("rw_freeze_end", 32'(freeze), 0);
        R = 0; NR = 0;

        // Press without end light lit does nothing.
        L = 1;
        step();
        L = 0;
        chk("nolight_left", 32'(leftScore), 1);
        chk("nolight_freeze", 32'(freeze), 0);

        // Left wins 2..6, each followed by a full hold.
        NL = 1;
        for (int w = 2; w <= 6; w++) begin
            L = 1; step(); L = 0;
            chk("run_left", 32'(leftScore), 32'(w));
            pulses = 0;
            for (int i = 0; i < 4; i++) begin
                step();
                if (roundReset) pulses++;
            end
            chk("run_pulses", 32'(pulses), 1);
        end
        chk("run_hexL6", 32'(hexL), 32'b0000010);

        // Seventh win ends the match.
        L = 1; step(); L = 0;
        chk("over_left", 32'(leftScore), 7);
        chk("over_ctl", {matchOver, freeze, roundReset}, 3'b110);
`ifdef SCORE_WINNER_LETTER_EN
        chk("over_hexL", 32'(hexL), 32'b1000111);
`else
        chk("over_hexL", 32'(hexL), 32'b1111000);
`endif
        chk("over_hexR", 32'(hexR), 32'b1111001);
        NR = 1;
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            L = i[0]; R = ~i[0];
            step();
            if (roundReset) pulses++;
        end
        L = 0; R = 0;
        chk("over_pulses", 32'(pulses), 0);
        chk("over_scores", {leftScore, rightScore}, {3'd7, 3'd1});
        chk("over_still", {matchOver, freeze}, 2'b11);

        // Reset in OVER clears immediately.
        reset = 1; #1;
        chk("ovr_rst", {leftScore, rightScore, matchOver, freeze}, 0);
        step(); reset = 0;

        // Reset asserted during cycle k+2 of a hold.
        NL = 1; L = 1; step(); L = 0;
        chk("mid_left", 32'(leftScore), 1);
        step(); step();
        reset = 1; #1;
        chk("mid_rst_scores", {leftScore, rightScore}, 0);
        chk("mid_rst_ctl", {freeze, roundReset, matchOver}, 0);
        chk("mid_rst_hex", {hexL, hexR}, {7'b1000000, 7'b1000000});
        step(); step();
        reset = 0;
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (roundReset || freeze) pulses++;
        end
        chk("mid_quiet", 32'(pulses), 0);
        NR = 1; R = 1; step(); R = 0;
        chk("mid_resume", {leftScore, rightScore, freeze}, {3'd0, 3'd1, 1'b1});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/tug_score_keeper.md
# tug_score_keeper

Match-level scorekeeper for the two-player tug-of-war game, directly downstream of the nine-light playfield. It consumes the single-cycle player press pulses and the two end-light states, decides who won each round, keeps a 0–7 win count per player on two seven-segment digits, and drives a one-cycle round-restart pulse that the top level ORs into the playfield reset. While a round result is being shown, and after the match ends, it asserts `freeze`, which the top level uses to gate player presses.

## Interface
- `HOLD_CYCLES`, default 4: number of cycles the round result is held before restart; must be ≥ 2.
- `WIN_SCORE`, default 7: score that ends the match; range 1–7.

Ports:
- `clk` in 1: system clock (CLOCK_50 at top level).
- `reset` in 1: asynchronous, active-high; clears all state.
- `L` in 1: left-player press, single-cycle pulse from the input conditioner.
- `R` in 1: right-player press, single-cycle pulse.
- `NL` in 1: leftmost playfield light (led9) is on.
- `NR` in 1: rightmost playfield light (led1) is on.
- `roundReset` out 1: one-cycle restart pulse to the playfield.
- `freeze` out 1: high while presses must be ignored.
- `matchOver` out 1: high once a player reaches `WIN_SCORE`.
- `leftScore` out 3: left win count.
- `rightScore` out 3: right win count.
- `hexL` out 7: active-low segments {g..a} showing `leftScore` (drives HEX5).
- `hexR` out 7: active-low segments {g..a} showing `rightScore` (drives HEX0).

## Operation
- Win decode, combinational:
  - `leftWin = L & ~R & NL`
  - `rightWin = R & ~L & NR`
  - Simultaneous L and R never scores.
- FSM states:
  - PLAY: on `leftWin`, increment `leftScore`; on `rightWin`, increment `rightScore`. If the new score equals `WIN_SCORE`, go to OVER. Otherwise go to HOLD and clear the hold counter.
  - HOLD: ignore L/R. The counter increments each cycle. When counter = `HOLD_CYCLES`-1, return to PLAY at the next edge.
  - OVER: ignore L/R. Stay in OVER until reset.
- `freeze` = state ≠ PLAY.
- `matchOver` = state == OVER.
- `roundReset` is high exactly during the HOLD cycle where counter = `HOLD_CYCLES`-1. It is driven from a flop, so it is glitch-free.
- Scores are 3-bit and saturate by construction: no increment occurs outside PLAY, and `WIN_SCORE` ≤ 7.
- Segment encoding, 0–7: 1000000, 1111001, 0100100, 0110000, 0011001, 0010010, 0000010, 1111000.
- Reset values:
  - state PLAY, counter 0.
  - `roundReset`, `freeze`, `matchOver` = 0.
  - `leftScore` = `rightScore` = 0.
  - `hexL` = `hexR` = 1000000.

## Timing
- Win sampled at edge k:
  - The score is updated at edge k.
  - `freeze` is high from edge k through the cycle before edge k+`HOLD_CYCLES`.
  - `roundReset` is high during cycle k+`HOLD_CYCLES`-1 only. The playfield resets at edge k+`HOLD_CYCLES`, the same edge at which state returns to PLAY.
- Presses arriving during HOLD or OVER never change scores, even if `NL`/`NR` is still high.
- A winning press at edge k in PLAY with the end light lit is the only scoring event. The end light staying lit afterwards does not rescore.
- Reset asserted mid-HOLD or in OVER:
  - All outputs return to reset values immediately (asynchronously).
  - No `roundReset` pulse is emitted.
- Hex outputs are combinational from the score registers. They change in the same cycle as the score.

## Configuration
- `SCORE_WINNER_LETTER_EN`, when defined: in OVER, the winner's digit shows a letter instead of the score.
  - Left winner: `hexL` = 1000111 ("L").
  - Right winner: `hexR` = 0101111 ("r").
  - The loser's digit keeps showing its score.
- When `SCORE_WINNER_LETTER_EN` is undefined: both digits show scores in all states.
- `matchOver` and all other outputs are identical with and without the macro.

## Test plan
- Reset, then no input for 10 cycles → scores 0/0, `hexL` = `hexR` = 1000000, `freeze` = `roundReset` = 0.
- `NL` = 1 with an `L` pulse at edge k (`HOLD_CYCLES` = 4) → `leftScore` = 1 at edge k, `hexL` = 1111001, `freeze` high for 4 cycles, `roundReset` high only in cycle k+3, state PLAY at k+4.
- `NR` = 1 with `L` and `R` pulsed in the same cycle → no score change, no `freeze`. Then an `R` pulse alone in PLAY → `rightScore` = 1.
- `L` pulses repeated during HOLD with `NL` held at 1 → `leftScore` stays 1. Exactly one `roundReset` pulse per won round.
- Seven left wins → `leftScore` = 7, `matchOver` = `freeze` = 1, no `roundReset` after the 7th win. Further presses are ignored. `hexL` = 1111000 without the macro, 1000111 with `SCORE_WINNER_LETTER_EN`.
- Assert `reset` during cycle k+2 of a HOLD → scores 0, `freeze` = 0 immediately, no `roundReset` pulse, and normal scoring resumes after reset deasserts.
